// File: rtl/uart_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_tx_queue
//
// Purpose:
//   Byte-queued UART transmitter. Bytes pushed on the tx_data/tx_valid
//   handshake are stored in a small FIFO and sent one frame at a time on
//   uart_txd: one start bit (low), PAYLOAD_BITS data bits LSB first, then
//   STOP_BITS stop bits (high). Each bit lasts CLK_HZ/BIT_RATE clock cycles.
//
// Ports:
//   clk          rising-edge clock for all logic
//   reset        synchronous, active-high; flushes the queue, aborts any frame
//   tx_data      byte to queue (only the low PAYLOAD_BITS bits are sent)
//   tx_valid     tx_data is valid this cycle
//   tx_ready     queue can accept a byte (registered count not at depth)
//   uart_tx_en   permits new frames to start; a running frame always finishes
//   uart_txd     registered serial line, idle high
//   tx_busy      a frame is in progress
//   fifo_count   bytes waiting in the queue (the byte being sent is excluded)
//   tx_overflow  sticky flag: a byte was offered while the queue was full
// ---------------------------------------------------------------------------
module uart_tx_queue #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          uart_tx_en,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam int STOP_CYCLES    = STOP_BITS * CYCLES_PER_BIT;
  // The stop phase is the longest single timer load, so size the timer for it.
  localparam int TIMER_W        = $clog2(STOP_CYCLES);
  localparam int BITCNT_W       = $clog2(PAYLOAD_BITS);

  // Reject parameter sets the datapath cannot represent.
  if (CYCLES_PER_BIT < 2) begin : gBadRate
    $error("uart_tx_queue: CLK_HZ/BIT_RATE must be at least 2");
  end
  if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 8) begin : gBadPayload
    $error("uart_tx_queue: PAYLOAD_BITS must be 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_queue: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_tx_queue: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [PAYLOAD_BITS-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [BITCNT_W-1:0]     bitCnt_q, bitCnt_d;
  logic                    txd_q, txd_d;

  logic full;
  logic push;
  logic pop;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never opens a slot for a push while the queue is full.
  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push = tx_valid && !full;
  assign pop  = (state_q == IDLE) && (count_q != '0) && uart_tx_en;

  assign tx_ready    = !full;
  assign tx_overflow = overflow_q;
  assign fifo_count  = count_q;
  assign uart_txd    = txd_q;
  assign tx_busy     = (state_q != IDLE);

  // Queue bookkeeping: pointers advance independently, the count only moves
  // when exactly one of push/pop happens, and overflow latches any offer
  // that arrives while full.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (tx_valid && full) begin
      overflow_d = 1'b1;
    end
  end

  // Queue storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifoMem_q[wrPtr_q] <= tx_data[PAYLOAD_BITS-1:0];
    end
  end

  // Frame sequencer. uart_txd is computed as a next-state value so the line
  // changes on the same edge the state changes, keeping every phase exactly
  // one timer load long. The data shift register presents the next bit in
  // position 0 and shifts right as each bit is launched.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    timer_d  = timer_q;
    bitCnt_d = bitCnt_q;
    txd_d    = txd_q;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d  = fifoMem_q[rdPtr_q];
          timer_d  = TIMER_W'(CYCLES_PER_BIT - 1);
          bitCnt_d = '0;
          txd_d    = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          timer_d = TIMER_W'(CYCLES_PER_BIT - 1);
          state_d = DATA;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          if (bitCnt_q == BITCNT_W'(PAYLOAD_BITS - 1)) begin
            txd_d   = 1'b1;
            timer_d = TIMER_W'(STOP_CYCLES - 1);
            state_d = STOP;
          end else begin
            txd_d    = shift_q[0];
            shift_d  = shift_q >> 1;
            bitCnt_d = bitCnt_q + BITCNT_W'(1);
            timer_d  = TIMER_W'(CYCLES_PER_BIT - 1);
          end
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State registers. Reset wins over everything, including a push in the
  // same cycle, and drops the line high immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      timer_q    <= '0;
      bitCnt_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      bitCnt_q   <= bitCnt_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_queue
//
// Directed bench for uart_tx_queue at 10 clock cycles per bit, 8 data bits,
// 1 stop bit, 16-deep queue. A small receiver model decodes the serial line
// independently and logs decoded text.
// ---------------------------------------------------------------------------
module tb_uart_tx_queue;

  localparam int CPB   = 10;
  localparam int FRAME = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx_en;
  logic       uart_txd;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       tx_overflow;

  int         checkCount = 0;
  int         errorCount = 0;
  logic [7:0] rxQ [$];
  string      rxLine = "";

  uart_tx_queue #(
    .BIT_RATE    (100_000),
    .CLK_HZ      (1_000_000),
    .PAYLOAD_BITS(8),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx_en (uart_tx_en),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .tx_overflow(tx_overflow)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case something never finishes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just past the edge, where outputs are read.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; tx_valid is a single-cycle pulse.
  task automatic applyStimulus(input logic en, input logic valid, input logic [7:0] data);
    uart_tx_en = en;
    tx_valid   = valid;
    tx_data    = data;
    tick();
    tx_valid   = 1'b0;
  endtask

  // Wait (bounded) for the line to drop; reports cycles waited.
  task automatic waitStart(output int n);
    n = 0;
    while (uart_txd !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    if (uart_txd !== 1'b0) begin
      checkOutput("startTimeout", {31'd0, uart_txd}, 32'd0);
    end
  endtask

  // Called on the first cycle of a start bit: compares every cycle of the
  // frame against the expected waveform and checks the frame length.
  task automatic expectFrame(input logic [7:0] b, input string tag);
    int   badTxd;
    int   busyCycles;
    logic expBit;
    badTxd     = 0;
    busyCycles = 0;
    for (int j = 0; j < FRAME; j++) begin
      if (j < CPB) begin
        expBit = 1'b0;
      end else if (j < 9 * CPB) begin
        expBit = b[(j - CPB) / CPB];
      end else begin
        expBit = 1'b1;
      end
      if (uart_txd !== expBit) badTxd++;
      if (tx_busy === 1'b1) busyCycles++;
      tick();
    end
    checkOutput({tag, " txdBadCycles"}, badTxd, 0);
    checkOutput({tag, " busyCycles"}, busyCycles, FRAME);
    checkOutput({tag, " idleAfter"}, {31'd0, tx_busy}, 32'd0);
  endtask

  // Compare the oldest byte decoded by the receiver model.
  task automatic checkRx(input logic [7:0] b, input string tag);
    int got;
    got = (rxQ.size() > 0) ? int'(rxQ.pop_front()) : -1;
    checkOutput(tag, got, {24'd0, b});
  endtask

  // Receiver wait helper: counts negedges and flags any reset seen.
  task automatic rxWait(input int n, inout logic aborted);
    repeat (n) begin
      @(negedge clk);
      if (reset === 1'b1) aborted = 1'b1;
    end
  endtask

  // Receiver model: finds the start edge, samples each bit near its middle,
  // validates framing and queues the byte. A reset mid-frame discards it.
  initial begin : rxModel
    logic [7:0] rxByte;
    logic       aborted;
    logic       startBit;
    logic       stopBit;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || uart_txd !== 1'b0) continue;
      aborted = 1'b0;
      rxWait(4, aborted);
      startBit = uart_txd;
      for (int i = 0; i < 8; i++) begin
        rxWait(CPB, aborted);
        rxByte[i] = uart_txd;
      end
      rxWait(CPB, aborted);
      stopBit = uart_txd;
      if (!aborted) begin
        checkOutput("rxStartBit", {31'd0, startBit}, 32'd0);
        checkOutput("rxStopBit", {31'd0, stopBit}, 32'd1);
        rxQ.push_back(rxByte);
        if (rxByte == 8'h0A) begin
          $display("[TB] TB_UART: %s", rxLine);
          rxLine = "";
        end else begin
          rxLine = $sformatf("%s%c", rxLine, rxByte);
        end
      end
    end
  end

  // Main directed sequence.
  initial begin : mainSeq
    int   n;
    int   lows;
    logic [7:0] hiBytes [3];
    hiBytes[0] = 8'h48;
    hiBytes[1] = 8'h69;
    hiBytes[2] = 8'h0A;

    reset      = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    uart_tx_en = 1'b0;
    repeat (2) tick();
    checkOutput("rst txd", {31'd0, uart_txd}, 32'd1);
    checkOutput("rst busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("rst count", {27'd0, fifo_count}, 32'd0);
    checkOutput("rst ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst overflow", {31'd0, tx_overflow}, 32'd0);
    reset = 1'b0;
    tick();

    // Single byte 0x41: start bit one cycle after the count goes to 1.
    $display("[TB] single byte 0x41");
    applyStimulus(1'b1, 1'b1, 8'h41);
    checkOutput("t1 count", {27'd0, fifo_count}, 32'd1);
    checkOutput("t1 txdIdle", {31'd0, uart_txd}, 32'd1);
    waitStart(n);
    checkOutput("t1 startLatency", n, 1);
    checkOutput("t1 countAfterPop", {27'd0, fifo_count}, 32'd0);
    expectFrame(8'h41, "t1 frame");
    checkRx(8'h41, "t1 rx");

    // "Hi\n": three contiguous frames separated by one idle cycle.
    $display("[TB] string Hi newline");
    rxLine = "";
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, hiBytes[i]);
    checkOutput("t2 count", {27'd0, fifo_count}, 32'd3);
    uart_tx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      waitStart(n);
      checkOutput($sformatf("t2 gap%0d", i), n, 1);
      expectFrame(hiBytes[i], $sformatf("t2 frame%0d", i));
    end
    for (int i = 0; i < 3; i++) checkRx(hiBytes[i], $sformatf("t2 rx%0d", i));

    // Fill to full with sending disabled, overflow on the 17th byte.
    $display("[TB] overflow fill");
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 1'b1, 8'(8'h10 + i));
    checkOutput("t3 countFull", {27'd0, fifo_count}, 32'd16);
    checkOutput("t3 readyFull", {31'd0, tx_ready}, 32'd0);
    checkOutput("t3 overflow", {31'd0, tx_overflow}, 32'd1);
    uart_tx_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waitStart(n);
      checkOutput($sformatf("t3 gap%0d", i), n, 1);
      expectFrame(8'(8'h10 + i), $sformatf("t3 frame%0d", i));
      checkRx(8'(8'h10 + i), $sformatf("t3 rx%0d", i));
    end
    lows = 0;
    repeat (150) begin
      tick();
      if (uart_txd !== 1'b1) lows++;
    end
    checkOutput("t3 noSeventeenth", lows, 0);
    checkOutput("t3 overflowSticky", {31'd0, tx_overflow}, 32'd1);

    // Reset during the data phase of a frame with more bytes queued.
    $display("[TB] reset mid-frame");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(8'hA1 + i));
    checkOutput("t4 count", {27'd0, fifo_count}, 32'd3);
    uart_tx_en = 1'b1;
    waitStart(n);
    checkOutput("t4 startLatency", n, 1);
    repeat (30) tick();
    checkOutput("t4 busyInData", {31'd0, tx_busy}, 32'd1);
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    tick();
    reset    = 1'b0;
    tx_valid = 1'b0;
    checkOutput("t4 txdAfterReset", {31'd0, uart_txd}, 32'd1);
    checkOutput("t4 countAfterReset", {27'd0, fifo_count}, 32'd0);
    checkOutput("t4 overflowCleared", {31'd0, tx_overflow}, 32'd0);
    checkOutput("t4 busyAfterReset", {31'd0, tx_busy}, 32'd0);
    checkOutput("t4 readyAfterReset", {31'd0, tx_ready}, 32'd1);
    lows = 0;
    repeat (300) begin
      tick();
      if (uart_txd !== 1'b1) lows++;
    end
    checkOutput("t4 noFurtherFrames", lows, 0);
    checkOutput("t4 countStaysZero", {27'd0, fifo_count}, 32'd0);
    checkOutput("t4 rxDiscarded", rxQ.size(), 0);

    // Enable dropped during the start bit: frame completes, next byte waits.
    $display("[TB] enable dropped mid-frame");
    applyStimulus(1'b0, 1'b1, 8'hC3);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    uart_tx_en = 1'b1;
    waitStart(n);
    checkOutput("t5 startLatency", n, 1);
    uart_tx_en = 1'b0;
    expectFrame(8'hC3, "t5 frameA");
    lows = 0;
    repeat (150) begin
      tick();
      if (uart_txd !== 1'b1) lows++;
    end
    checkOutput("t5 heldWhileDisabled", lows, 0);
    checkOutput("t5 countHeld", {27'd0, fifo_count}, 32'd1);
    uart_tx_en = 1'b1;
    waitStart(n);
    checkOutput("t5 resumeLatency", n, 1);
    expectFrame(8'h3C, "t5 frameB");
    checkRx(8'hC3, "t5 rxA");
    checkRx(8'h3C, "t5 rxB");

    // Push in the same cycle as the idle pop with one byte queued.
    $display("[TB] simultaneous push and pop");
    applyStimulus(1'b0, 1'b1, 8'h5A);
    checkOutput("t6 countBefore", {27'd0, fifo_count}, 32'd1);
    applyStimulus(1'b1, 1'b1, 8'hE7);
    checkOutput("t6 countSame", {27'd0, fifo_count}, 32'd1);
    checkOutput("t6 startNow", {31'd0, uart_txd}, 32'd0);
    expectFrame(8'h5A, "t6 frameA");
    waitStart(n);
    checkOutput("t6 gap", n, 1);
    expectFrame(8'hE7, "t6 frameB");
    checkRx(8'h5A, "t6 rxA");
    checkRx(8'hE7, "t6 rxB");

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
